// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and default sizing for the D-stage hazard scoreboard.
// A Tuse/Tnew code of 3 means "operand not read" / "no result produced".
package hazard_scoreboard_pkg;

    localparam int N_STG    = 3;
    localparam int AW       = 5;
    localparam int TW       = 2;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int CW       = 4;

    localparam logic [1:0] TUSE_0  = 2'd0;
    localparam logic [1:0] TUSE_1  = 2'd1;
    localparam logic [1:0] TUSE_2  = 2'd2;
    localparam logic [1:0] TUSE_NO = 2'd3;

    localparam logic [1:0] TNEW_0  = 2'd0;
    localparam logic [1:0] TNEW_1  = 2'd1;
    localparam logic [1:0] TNEW_2  = 2'd2;
    localparam logic [1:0] TNEW_NO = 2'd3;

    localparam logic [1:0] FWD_GRF = 2'd0;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Per-operand hazard check: finds the youngest in-flight producer of x and
// decides whether D must stall for it or can take its value from the bypass.
module sb_match #(
    parameter int N_STG = hazard_scoreboard_pkg::N_STG,
    parameter int AW    = hazard_scoreboard_pkg::AW,
    parameter int TW    = hazard_scoreboard_pkg::TW
) (
    input  logic [AW-1:0]            x,
    input  logic [TW-1:0]            tuse,
    input  logic [N_STG-1:0]         ent_v,
    input  logic [N_STG-1:0][AW-1:0] ent_wa,
    input  logic [N_STG-1:0][TW-1:0] ent_tnew,
    output logic                     stall_x,
    output logic [1:0]               fwd_sel
);
    import hazard_scoreboard_pkg::*;

    logic [N_STG-1:0] hit;

    for (genvar gi = 0; gi < N_STG; gi++) begin : g_hit
        assign hit[gi] = ent_v[gi] && (ent_wa[gi] == x) && (x != '0);
    end

    // Walk oldest to youngest so the youngest hit overwrites older ones.
    always_comb begin
        stall_x = 1'b0;
        fwd_sel = FWD_GRF;
        for (int k = N_STG - 1; k >= 0; k--) begin
            if (hit[k]) begin
                stall_x = (tuse != TW'(TUSE_NO)) && (ent_tnew[k] > tuse);
                fwd_sel = (ent_tnew[k] == TW'(TNEW_0)) ? 2'(k + 1) : FWD_GRF;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage stall/forward controller: shift-register scoreboard of in-flight
// producers plus the mult/div busy countdown that blocks HI/LO users.
module hazard_scoreboard #(
    parameter int N_STG    = hazard_scoreboard_pkg::N_STG,
    parameter int AW       = hazard_scoreboard_pkg::AW,
    parameter int TW       = hazard_scoreboard_pkg::TW,
    parameter int MULT_LAT = hazard_scoreboard_pkg::MULT_LAT,
    parameter int DIV_LAT  = hazard_scoreboard_pkg::DIV_LAT,
    parameter int CW       = hazard_scoreboard_pkg::CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [AW-1:0] d_wa,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md_use,
    input  logic          e_md_start,
    input  logic          e_md_div,
    input  logic          flush,
    output logic          stall,
    output logic [1:0]    fwd_rs_sel,
    output logic [1:0]    fwd_rt_sel,
    output logic          md_busy
);
    import hazard_scoreboard_pkg::*;

    logic [N_STG-1:0]         v_reg;
    logic [N_STG-1:0][AW-1:0] wa_reg;
    logic [N_STG-1:0][TW-1:0] tnew_reg;
    logic [CW-1:0]            md_cnt_reg;
    logic [CW-1:0]            md_cnt_next;

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall_int;
    logic load_v;

    // One pipeline step closer to producing: saturate at 0, "no result" is sticky.
    function automatic logic [TW-1:0] age(input logic [TW-1:0] t);
        if (t == TW'(TNEW_NO) || t == '0) return t;
        return t - TW'(1);
    endfunction

    sb_match #(.N_STG(N_STG), .AW(AW), .TW(TW)) u_match_rs (
        .x        (d_rs),
        .tuse     (d_tuse_rs),
        .ent_v    (v_reg),
        .ent_wa   (wa_reg),
        .ent_tnew (tnew_reg),
        .stall_x  (stall_rs),
        .fwd_sel  (fwd_rs_sel)
    );

    sb_match #(.N_STG(N_STG), .AW(AW), .TW(TW)) u_match_rt (
        .x        (d_rt),
        .tuse     (d_tuse_rt),
        .ent_v    (v_reg),
        .ent_wa   (wa_reg),
        .ent_tnew (tnew_reg),
        .stall_x  (stall_rt),
        .fwd_sel  (fwd_rt_sel)
    );

    assign md_busy   = (md_cnt_reg != '0);
    assign stall_md  = d_md_use && (md_busy || e_md_start);
    assign stall_int = d_valid && (stall_rs || stall_rt || stall_md);
    assign stall     = stall_int && !reset;

    // Only instructions that really write a nonzero register become producers.
    assign load_v = d_valid && !stall_int && (d_wa != '0) && (d_tnew != TW'(TNEW_NO));

    always_comb begin
        md_cnt_next = md_cnt_reg;
        if (e_md_start) begin
            md_cnt_next = e_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (md_cnt_reg != '0) begin
            md_cnt_next = md_cnt_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_reg      <= '0;
            wa_reg     <= '0;
            tnew_reg   <= '0;
            md_cnt_reg <= '0;
        end else begin
            for (int k = N_STG - 1; k > 0; k--) begin
                v_reg[k]    <= v_reg[k-1] && !flush;
                wa_reg[k]   <= wa_reg[k-1];
                tnew_reg[k] <= age(tnew_reg[k-1]);
            end
            v_reg[0]    <= load_v && !flush;
            wa_reg[0]   <= d_wa;
            tnew_reg[0] <= d_tnew;
            // The mult/div unit keeps running across a flush.
            md_cnt_reg  <= md_cnt_next;
        end
    end

endmodule
